// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory,
// and flags fetch-address errors for the IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
    parameter logic [31:0] TEXT_END   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        d_is_branch,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc_if,
    output logic [31:0] instr_if,
    output logic [31:0] pc4_if,
    output logic [31:0] pc8_if,
    output logic        exc_adel_if,
    output logic        bd_if
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc4;
    logic        adel;

    assign pc4 = pc_q + 32'd4;

    // Exception entry and eret bypass the stall; a stalled branch is re-presented by D.
    always_comb begin
        pc_d = pc4;
        if (exc_req) begin
            pc_d = EXC_VECTOR;
        end else if (eret_req) begin
            pc_d = epc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (br_valid) begin
            pc_d = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign adel = (pc_q[1:0] != 2'b00)
                | (pc_q < TEXT_BASE)
                | (pc_q > TEXT_END);

    assign im_addr     = pc_q;
    assign pc_if       = pc_q;
    assign pc4_if      = pc4;
    assign pc8_if      = pc_q + 32'd8;
    assign exc_adel_if = adel;
    assign instr_if    = adel ? 32'h0000_0000 : im_rdata;
    assign bd_if       = d_is_branch;

endmodule
